// File: rtl/lfsr_checker_if.sv
// -----------------------------------------------------------------------------
// lfsr_checker_if
//
// Word stream from the 5-bit LFSR pattern generator, or from whatever path it
// drives, to the lfsr_checker.
//
// Handshake: in_valid qualifies in_data. A word is accepted on every rising
// clock edge where in_valid is 1. There is no ready signal. The checker never
// stalls, so the source may present a new word every cycle.
//
// Signals:
//   in_valid  1  in_data carries a sequence word this cycle
//   in_data   5  received word
//
// Modports:
//   master  drives the stream (generator side / testbench)
//   slave   receives the stream (lfsr_checker)
// -----------------------------------------------------------------------------
interface lfsr_checker_if;
  logic       in_valid;
  logic [4:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//
// Receive-side checker for the 5-bit LFSR pattern (x^5 + x^2 + 1, period 31).
// It seeds from the first valid word. It then requires LOCK_CNT consecutive
// correctly-predicted words before declaring lock. Once locked, it checks every
// word against the predicted successor. A mismatch does not reseed. The
// prediction keeps advancing from its own expected value (flywheel), so that a
// single corrupted word produces exactly one error. LOSS_CNT consecutive
// mismatches drop back to HUNT.
//
// Optional feature (compile-time macro LFSR_CHECKER_ZERO_DETECT_EN):
//   When defined, an all-zero word is never accepted as a seed or reseed, and it
//   is always a mismatch in LOCKED. When undefined, zero is an ordinary word.
//   A zero seed then predicts zero forever.
//
// Parameters:
//   LOCK_CNT  consecutive matches after the seed needed to lock (>= 1)
//   LOSS_CNT  consecutive locked mismatches that drop lock (>= 1)
//   ERR_W     width of the saturating error counter
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   rx           word stream (lfsr_checker_if.slave: in_valid, in_data)
//   clr_err      synchronous clear of err_count
//   locked       registered, high while in LOCKED
//   err_pulse    registered, one-cycle pulse per locked mismatch
//   err_count    saturating count of locked mismatches
//   wrap         registered, one-cycle pulse on an accepted locked match of 5'h0F
//   dbg_state_o  current FSM state (0 HUNT, 1 SYNC, 2 LOCKED)
// -----------------------------------------------------------------------------
module lfsr_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  lfsr_checker_if.slave    rx,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap,
  output logic [1:0]       dbg_state_o
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic logic [4:0] lfsr_next(input logic [4:0] x);
    return {x[3:0], x[4] ^ x[1]};
  endfunction

  state_e           state_q, state_d;
  logic [4:0]       exp_q, exp_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             count_err;
  logic             zero_rej;
  logic             word_hit;

  // zero_rej marks a word that must not be used as a seed and can never match.
`ifdef LFSR_CHECKER_ZERO_DETECT_EN
  assign zero_rej = (rx.in_data == 5'd0);
`else
  assign zero_rej = 1'b0;
`endif

  assign word_hit = (rx.in_data == exp_q) && !zero_rej;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    wrap_d      = 1'b0;
    count_err   = 1'b0;

    if (rx.in_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (!zero_rej) begin
            exp_d   = lfsr_next(rx.in_data);
            match_d = '0;
            state_d = ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (zero_rej) begin
            state_d = ST_HUNT;
          end else if (word_hit) begin
            exp_d   = lfsr_next(rx.in_data);
            match_d = match_q + MW'(1);
            if (match_q + MW'(1) == MW'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else begin
            // Mismatch before lock: reseed from this word. No error is counted.
            exp_d   = lfsr_next(rx.in_data);
            match_d = '0;
          end
        end

        ST_LOCKED: begin
          if (word_hit) begin
            exp_d  = lfsr_next(rx.in_data);
            miss_d = '0;
            wrap_d = (rx.in_data == 5'h0F);
          end else begin
            // Flywheel: advance from our own prediction, not the bad word.
            exp_d       = lfsr_next(exp_q);
            err_pulse_d = 1'b1;
            count_err   = 1'b1;
            miss_d      = miss_q + LW'(1);
            if (miss_q + LW'(1) == LW'(LOSS_CNT)) begin
              state_d = ST_HUNT;
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);

    // A clear wins over accumulated history. An error counted in the same
    // cycle still shows up as a count of one.
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = count_err ? ERR_W'(1) : '0;
    end else if (count_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HUNT;
      exp_q       <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      wrap_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      wrap_q      <= wrap_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked      = locked_q;
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_cnt_q;
  assign wrap        = wrap_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
//
// Two checkers share one word stream: one with a 16-bit error counter and one
// with a 4-bit counter, so saturation shows up on the narrow one. A reference
// model walks the 31-entry LFSR sequence table. It follows the hunt/sync/lock
// rules and is compared with both DUTs one step after every rising edge.
// Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

`ifdef LFSR_CHECKER_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_err = 1'b0;
  always #5 clk = ~clk;

  lfsr_checker_if bus ();

  logic        locked_a, pulse_a, wrap_a;
  logic [15:0] cnt_a;
  logic [1:0]  st_a;
  logic        locked_b, pulse_b, wrap_b;
  logic [3:0]  cnt_b;
  logic [1:0]  st_b;

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut_a (
    .clk(clk), .rst(rst), .rx(bus), .clr_err(clr_err),
    .locked(locked_a), .err_pulse(pulse_a), .err_count(cnt_a),
    .wrap(wrap_a), .dbg_state_o(st_a)
  );

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(4)) dut_b (
    .clk(clk), .rst(rst), .rx(bus), .clr_err(clr_err),
    .locked(locked_b), .err_pulse(pulse_b), .err_count(cnt_b),
    .wrap(wrap_b), .dbg_state_o(st_b)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The full maximal-length sequence, listed out. The successor is looked up.
  logic [4:0] seq_tab [31] = '{
    5'h01, 5'h02, 5'h05, 5'h0A, 5'h15, 5'h0B, 5'h17, 5'h0E, 5'h1D, 5'h1B,
    5'h16, 5'h0C, 5'h18, 5'h11, 5'h03, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C,
    5'h19, 5'h13, 5'h06, 5'h0D, 5'h1A, 5'h14, 5'h09, 5'h12, 5'h04, 5'h08,
    5'h10
  };

  function automatic logic [4:0] succ(input logic [4:0] d);
    for (int i = 0; i < 31; i++) begin
      if (seq_tab[i] == d) return seq_tab[(i + 1) % 31];
    end
    return 5'h00;  // zero maps to zero
  endfunction

  // m_mode: 0 hunting, 1 synchronising, 2 locked
  int         m_mode;
  logic [4:0] m_exp;
  int         m_run, m_miss, m_cnt_a, m_cnt_b;
  int         m_locked, m_pulse, m_wrap;

  task automatic model_reset();
    m_mode = 0; m_exp = 5'h00; m_run = 0; m_miss = 0;
    m_cnt_a = 0; m_cnt_b = 0; m_locked = 0; m_pulse = 0; m_wrap = 0;
  endtask

  task automatic model_step(input logic v, input logic [4:0] d, input logic c);
    bit err;
    bit bad_zero;
    err = 1'b0;
    m_pulse = 0;
    m_wrap = 0;
    bad_zero = ZD && (d == 5'h00);
    if (v) begin
      if (m_mode == 0) begin
        if (!bad_zero) begin m_exp = succ(d); m_run = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (bad_zero) m_mode = 0;
        else if (d == m_exp) begin
          m_run++; m_exp = succ(d);
          if (m_run == 4) begin m_mode = 2; m_miss = 0; end
        end else begin
          m_exp = succ(d); m_run = 0;
        end
      end else begin
        if (d == m_exp && !bad_zero) begin
          m_miss = 0; m_exp = succ(d); m_wrap = (d == 5'h0F) ? 1 : 0;
        end else begin
          m_exp = succ(m_exp); m_pulse = 1; err = 1'b1; m_miss++;
          if (m_miss == 3) m_mode = 0;
        end
      end
    end
    if (c) begin
      m_cnt_a = err ? 1 : 0;
      m_cnt_b = err ? 1 : 0;
    end else if (err) begin
      if (m_cnt_a < 65535) m_cnt_a++;
      if (m_cnt_b < 15) m_cnt_b++;
    end
    m_locked = (m_mode == 2) ? 1 : 0;
  endtask

  initial model_reset();

  // ---------------- scoreboard: compare every cycle ----------------
  initial begin
    logic       s_rst, s_v, s_c;
    logic [4:0] s_d;
    forever begin
      @(posedge clk);
      s_rst = rst; s_v = bus.in_valid; s_d = bus.in_data; s_c = clr_err;
      #1;
      if (!s_rst) model_reset();
      else model_step(s_v, s_d, s_c);
      chk("locked_a",    int'(locked_a), m_locked);
      chk("err_pulse_a", int'(pulse_a),  m_pulse);
      chk("wrap_a",      int'(wrap_a),   m_wrap);
      chk("err_count_a", int'(cnt_a),    m_cnt_a);
      chk("locked_b",    int'(locked_b), m_locked);
      chk("err_pulse_b", int'(pulse_b),  m_pulse);
      chk("wrap_b",      int'(wrap_b),   m_wrap);
      chk("err_count_b", int'(cnt_b),    m_cnt_b);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge. Inputs are held over the next rising edge, and
  // the task returns at the following falling edge with the response visible.
  task automatic send(input logic v, input logic [4:0] d, input logic c);
    bus.in_valid = v;
    bus.in_data  = d;
    clr_err      = c;
    @(negedge clk);
  endtask

  logic [4:0] cur;

  task automatic good();
    send(1'b1, cur, 1'b0);
    cur = succ(cur);
  endtask

  task automatic bad(input logic c);
    send(1'b1, cur ^ 5'h01, c);
    cur = succ(cur);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  int pulses;
  int nwrap;
  int wpos[2];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 5'h00;
    clr_err      = 1'b0;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_locked", int'(locked_a), 0);
    chk("reset_count",  int'(cnt_a),    0);
    chk("reset_wrap",   int'(wrap_a),   0);
    chk("reset_pulse",  int'(pulse_a),  0);
    rst = 1'b1;

    // Seed 0F, then 1F 1E 1C 19. Lock comes after the 19 edge.
    cur = 5'h0F;
    repeat (4) good();
    chk("not_yet_locked", int'(locked_a), 0);
    good();
    chk("lock_after_19", int'(locked_a), 1);
    chk("lock_count0",   int'(cnt_a),    0);
    chk("lock_wrap0",    int'(wrap_a),   0);

    // Corrupt one word (1C sent as 1D), then continue correctly.
    while (cur != 5'h1C) good();
    pulses = 0;
    bad(1'b0);          // 1C ^ 01 = 1D
    pulses += int'(pulse_a);
    repeat (2) begin good(); pulses += int'(pulse_a); end
    chk("single_err_pulses", pulses,          1);
    chk("single_err_count",  int'(cnt_a),     1);
    chk("single_err_locked", int'(locked_a),  1);

    // Three consecutive wrong words drop lock.
    pulses = 0;
    bad(1'b0); pulses += int'(pulse_a);
    bad(1'b0); pulses += int'(pulse_a);
    chk("loss_still_locked", int'(locked_a), 1);
    bad(1'b0); pulses += int'(pulse_a);
    chk("loss_pulses",   pulses,         3);
    chk("loss_unlocked", int'(locked_a), 0);
    chk("loss_count",    int'(cnt_a),    4);
    repeat (4) good();
    chk("relock_pending", int'(locked_a), 0);
    good();
    chk("relock", int'(locked_a), 1);

    // 62 correct words with idle gaps: exactly two wraps, 31 words apart.
    nwrap = 0;
    for (int i = 0; i < 62; i++) begin
      if (i % 7 == 3) send(1'b0, 5'h0F, 1'b0);
      good();
      if (wrap_a) begin
        if (nwrap < 2) wpos[nwrap] = i;
        nwrap++;
      end
    end
    chk("wrap_count", nwrap, 2);
    if (nwrap >= 2) chk("wrap_spacing", wpos[1] - wpos[0], 31);
    chk("wrap_locked", int'(locked_a), 1);

    // Six loss/relock rounds add 18 errors: 22 total, 4-bit counter saturates.
    repeat (6) begin
      repeat (3) bad(1'b0);
      repeat (5) good();
    end
    chk("sat_count_16", int'(cnt_a),    22);
    chk("sat_count_4",  int'(cnt_b),    15);
    chk("sat_locked",   int'(locked_a), 1);

    // Clear together with an error gives 1, and a later error makes it 2.
    bad(1'b1);
    chk("clr_with_err_16", int'(cnt_a), 1);
    chk("clr_with_err_4",  int'(cnt_b), 1);
    bad(1'b0);
    chk("after_clr_err", int'(cnt_b), 2);
    send(1'b0, 5'h00, 1'b1);
    chk("clr_only_16", int'(cnt_a), 0);
    chk("clr_only_4",  int'(cnt_b), 0);
    repeat (3) good();
    bad(1'b0);
    repeat (2) good();
    chk("pre_rst_locked", int'(locked_a), 1);
    chk("pre_rst_count",  int'(cnt_a),    1);

    // Asynchronous reset mid-cycle clears outputs without waiting for a clock edge.
    #2 rst = 1'b0;
    #1;
    chk("async_rst_locked", int'(locked_a), 0);
    chk("async_rst_count",  int'(cnt_a),    0);
    @(negedge clk);
    rst = 1'b1;

    // All-zero stream after reset.
    repeat (4) send(1'b1, 5'h00, 1'b0);
    chk("zero_4th_unlocked", int'(locked_a), 0);
    send(1'b1, 5'h00, 1'b0);
    chk("zero_lock_5th", int'(locked_a), ZD ? 0 : 1);
    send(1'b1, 5'h00, 1'b0);
    chk("zero_lock_6th", int'(locked_a), ZD ? 0 : 1);

    // Normal stream after the zeros: resynchronise through whatever path applies.
    cur = 5'h07;
    repeat (14) good();
    chk("final_locked", int'(locked_a), 1);

    send(1'b0, 5'h00, 1'b0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
